// File: rtl/matrix_pkg.sv
// Shared definitions for the LED strip frame scheduler.
//   state_e      : frame FSM states
//   START_BITS   : zero bits of the APA102 start frame
//   END_BITS     : zero bits of the end frame
//   WORD_BITS    : bits per pixel word
//   GRANT_*      : one-hot grant encoding (bit n = producer n)
//   cap_bright() : clamp the 5-bit global-brightness field of a pixel word
package matrix_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StPixel,
        StEnd,
        StGap
    } state_e;

    localparam int unsigned START_BITS = 32;
    localparam int unsigned END_BITS   = 64;
    localparam int unsigned WORD_BITS  = 32;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_P0   = 2'b01;
    localparam logic [1:0] GRANT_P1   = 2'b10;

    function automatic logic [31:0] cap_bright(input logic [31:0] word,
                                               input logic [4:0]  ceiling);
        logic [31:0] r;
        r = word;
        if (word[28:24] > ceiling) begin
            r[28:24] = ceiling;
        end
        return r;
    endfunction

endpackage

// File: rtl/strip_serializer.sv
// Bit-level serializer for the LED strip.
// Owns the 32-bit shifter, the strip_clk toggle and the stall hold.
// Each bit spends one cycle with strip_clk low, then one with it high; strip_data only
// advances on the edge that drives strip_clk low. Load takes priority over hold,
// hold over run; with none of them asserted the outputs are parked at zero.
// Ports:
//   clk, reset_n   : clock, synchronous active-low reset
//   run            : shifting enabled (frame in progress)
//   load/load_word : load a new word at this edge, MSB presented next cycle
//   hold           : word needed but not available; park strip_clk low, keep strip_data
//   strip_clk/data : serial strip outputs
//   word_end       : current cycle is the high half of the last bit of a word
module strip_serializer
    import matrix_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 run,
    input  logic                 load,
    input  logic                 hold,
    input  logic [WORD_BITS-1:0] load_word,
    output logic                 strip_clk,
    output logic                 strip_data,
    output logic                 word_end
);

    localparam int unsigned IDX_W = $clog2(WORD_BITS);

    logic [WORD_BITS-1:0] shift_q;
    logic [IDX_W-1:0]     bit_idx_q;
    logic                 sclk_q;
    logic                 sdata_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            shift_q   <= '0;
            bit_idx_q <= '0;
            sclk_q    <= 1'b0;
            sdata_q   <= 1'b0;
        end else if (load) begin
            shift_q   <= load_word;
            sdata_q   <= load_word[WORD_BITS-1];
            sclk_q    <= 1'b0;
            bit_idx_q <= '0;
        end else if (hold) begin
            // Bit just finished; drop the clock but keep the last data bit on the line.
            sclk_q <= 1'b0;
        end else if (run) begin
            if (!sclk_q) begin
                sclk_q <= 1'b1;
            end else begin
                sclk_q    <= 1'b0;
                shift_q   <= {shift_q[WORD_BITS-2:0], 1'b0};
                sdata_q   <= shift_q[WORD_BITS-2];
                bit_idx_q <= bit_idx_q + 1'b1;
            end
        end else begin
            shift_q   <= '0;
            bit_idx_q <= '0;
            sclk_q    <= 1'b0;
            sdata_q   <= 1'b0;
        end
    end

    assign strip_clk  = sclk_q;
    assign strip_data = sdata_q;
    assign word_end   = sclk_q && (bit_idx_q == IDX_W'(WORD_BITS - 1));

endmodule

// File: rtl/strip_frame_sched.sv
// Two-producer APA102 LED strip frame scheduler.
// Arbitrates round-robin between two producers, then streams one frame: 32 zero bits,
// NUM_LEDS pixel words fetched by valid/ready handshake, 64 zero bits, followed by
// FRAME_GAP idle cycles. A late pixel word stalls the serial clock without losing bits.
// Optional build macro STRIP_BRIGHT_CAP_EN: clamps the brightness field (bits[28:24]) of
// every accepted word to BRIGHT_MAX; without it words pass unchanged.
// Ports:
//   clk, reset_n           : clock, synchronous active-low reset
//   req0/1                 : producer requests a frame
//   pix_data0/1, valid0/1  : pixel word offer from each producer
//   pix_ready0/1           : word accepted from the granted producer
//   grant                  : one-hot frame owner
//   strip_clk, strip_data  : serial strip interface
//   busy, frame_done       : frame in progress (START..GAP); one-cycle end-of-frame pulse
module strip_frame_sched
    import matrix_pkg::*;
#(
    parameter int unsigned NUM_LEDS   = 64,
    parameter int unsigned FRAME_GAP  = 1000,
    parameter logic [4:0]  BRIGHT_MAX = 5'd8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req0,
    input  logic        req1,
    input  logic [31:0] pix_data0,
    input  logic [31:0] pix_data1,
    input  logic        pix_valid0,
    input  logic        pix_valid1,
    output logic        pix_ready0,
    output logic        pix_ready1,
    output logic [1:0]  grant,
    output logic        strip_clk,
    output logic        strip_data,
    output logic        busy,
    output logic        frame_done
);

    localparam int unsigned TOTAL_BITS = START_BITS + WORD_BITS * NUM_LEDS + END_BITS;
    localparam int unsigned BIT_W      = $clog2(TOTAL_BITS + 1);
    localparam int unsigned LED_W      = $clog2(NUM_LEDS + 1);

    state_e           state_q, state_d;
    logic [1:0]       grant_q, grant_d;
    logic             ptr_q, ptr_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [LED_W-1:0] led_cnt_q, led_cnt_d;
    logic [31:0]      gap_cnt_q, gap_cnt_d;
    logic             wait_q, wait_d;
    logic             done_q, done_d;

    logic        word_end;
    logic        need_word;
    logic        handshake;
    logic        hold;
    logic        load;
    logic        run;
    logic        last_bit;
    logic        leds_done;
    logic        winner;
    logic        valid_g;
    logic [31:0] data_g;
    logic [31:0] data_cap;
    logic [31:0] word_in;

    assign valid_g = grant_q[1] ? pix_valid1 : pix_valid0;
    assign data_g  = grant_q[1] ? pix_data1  : pix_data0;

`ifdef STRIP_BRIGHT_CAP_EN
    assign data_cap = cap_bright(data_g, BRIGHT_MAX);
`else
    assign data_cap = data_g;
`endif

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        bit_cnt_d = bit_cnt_q;
        led_cnt_d = led_cnt_q;
        gap_cnt_d = gap_cnt_q;
        done_d    = 1'b0;
        winner    = 1'b0;

        leds_done = (led_cnt_q == LED_W'(NUM_LEDS));
        // A pixel word is wanted at the end of the start frame, after every pixel word
        // but the last, and on every cycle of a stall until the producer delivers.
        need_word = ((state_q == StStart) && word_end) ||
                    ((state_q == StPixel) && (word_end || wait_q) && !leds_done);
        handshake = need_word && valid_g;
        hold      = need_word && !valid_g;
        wait_d    = hold;
        last_bit  = (state_q == StEnd) && word_end && (bit_cnt_q == BIT_W'(TOTAL_BITS - 1));
        run       = (state_q inside {StStart, StPixel, StEnd}) && !last_bit;
        // After the last pixel, reload zeros for the end frame.
        load      = handshake || ((state_q == StPixel) && word_end && leds_done);
        word_in   = handshake ? data_cap : '0;

        // strip_clk high means the current bit completes at this edge.
        if (run && strip_clk) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
        end
        if (handshake) begin
            led_cnt_d = led_cnt_q + 1'b1;
        end

        case (state_q)
            StIdle: begin
                bit_cnt_d = '0;
                led_cnt_d = '0;
                gap_cnt_d = '0;
                if (req0 || req1) begin
                    winner  = (req0 && req1) ? ptr_q : req1;
                    grant_d = winner ? GRANT_P1 : GRANT_P0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (word_end) begin
                    state_d = StPixel;
                end
            end
            StPixel: begin
                if (word_end && leds_done) begin
                    state_d = StEnd;
                end
            end
            StEnd: begin
                if (last_bit) begin
                    state_d = StGap;
                    done_d  = 1'b1;
                    ptr_d   = ~grant_q[1];
                end
            end
            StGap: begin
                gap_cnt_d = gap_cnt_q + 32'd1;
                if (gap_cnt_q + 32'd1 >= FRAME_GAP) begin
                    state_d   = StIdle;
                    grant_d   = GRANT_NONE;
                    gap_cnt_d = '0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            grant_q   <= GRANT_NONE;
            ptr_q     <= 1'b0;
            bit_cnt_q <= '0;
            led_cnt_q <= '0;
            gap_cnt_q <= '0;
            wait_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            ptr_q     <= ptr_d;
            bit_cnt_q <= bit_cnt_d;
            led_cnt_q <= led_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            wait_q    <= wait_d;
            done_q    <= done_d;
        end
    end

    strip_serializer u_serializer (
        .clk        (clk),
        .reset_n    (reset_n),
        .run        (run),
        .load       (load),
        .hold       (hold),
        .load_word  (word_in),
        .strip_clk  (strip_clk),
        .strip_data (strip_data),
        .word_end   (word_end)
    );

    assign grant      = grant_q;
    assign busy       = (state_q != StIdle);
    assign frame_done = done_q;
    assign pix_ready0 = need_word && grant_q[0];
    assign pix_ready1 = need_word && grant_q[1];

endmodule

// File: tb/tb_strip_frame_sched.sv
// Directed bench for strip_frame_sched with NUM_LEDS=4 and a short frame gap.
// The serial stream is captured on strip_clk rising and compared word by word with
// hand-derived frames; brightness expectations follow STRIP_BRIGHT_CAP_EN.
module tb_strip_frame_sched;

    localparam int unsigned NUM_LEDS   = 4;
    localparam int unsigned FRAME_GAP  = 20;
    localparam logic [4:0]  BRIGHT_MAX = 5'd8;
    localparam int FRAME_BITS = 32 + 32 * NUM_LEDS + 64;  // 224
    localparam int FRAME_CYC  = 2 * FRAME_BITS;           // 448

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req0, req1;
    logic [31:0] pix_data0, pix_data1;
    logic        pix_valid0, pix_valid1;
    logic        pix_ready0, pix_ready1;
    logic [1:0]  grant;
    logic        strip_clk, strip_data, busy, frame_done;

    strip_frame_sched #(
        .NUM_LEDS   (NUM_LEDS),
        .FRAME_GAP  (FRAME_GAP),
        .BRIGHT_MAX (BRIGHT_MAX)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req0       (req0),
        .req1       (req1),
        .pix_data0  (pix_data0),
        .pix_data1  (pix_data1),
        .pix_valid0 (pix_valid0),
        .pix_valid1 (pix_valid1),
        .pix_ready0 (pix_ready0),
        .pix_ready1 (pix_ready1),
        .grant      (grant),
        .strip_clk  (strip_clk),
        .strip_data (strip_data),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int failed = 0;
    int cyc = 0;

    // Producers offer base + (number of words accepted since the frame's snapshot).
    logic [31:0] base0 = '0, base1 = '0;
    int hs0 = 0, hs1 = 0, hs_base0 = 0, hs_base1 = 0;
    assign pix_data0 = base0 + 32'(hs0 - hs_base0);
    assign pix_data1 = base1 + 32'(hs1 - hs_base1);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pix_ready0 && pix_valid0) hs0 <= hs0 + 1;
        if (pix_ready1 && pix_valid1) hs1 <= hs1 + 1;
    end

    logic bits_q[$];
    logic sclk_prev = 1'b0;
    int   done_cnt = 0;
    bit   bad_ready = 1'b0;

    always @(negedge clk) begin
        if (strip_clk && !sclk_prev) bits_q.push_back(strip_data);
        sclk_prev = strip_clk;
        if (frame_done) done_cnt++;
        if ((pix_ready0 && !grant[0]) || (pix_ready1 && !grant[1])) bad_ready = 1'b1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] get_word(input int s);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) r = {r[30:0], bits_q[s + i]};
        return r;
    endfunction

    function automatic logic [31:0] model_word(input logic [31:0] w);
        logic [31:0] r;
        r = w;
`ifdef STRIP_BRIGHT_CAP_EN
        if (r[28:24] > BRIGHT_MAX) r[28:24] = BRIGHT_MAX;
`endif
        return r;
    endfunction

    // Waits for a fresh frame start (busy rising); t = cycle stamp of START's first cycle.
    task automatic wait_start(input string tag, output int t);
        int n;
        n = 0;
        while (busy && n < 3000) begin @(negedge clk); n++; end
        while (!busy && n < 3000) begin @(negedge clk); n++; end
        if (!busy) chk({tag, "_timeout"}, 64'(busy), 64'd1);
        t = cyc;
    endtask

    task automatic wait_done(input string tag, output int t);
        int n;
        n = 0;
        while (!frame_done && n < 3000) begin @(negedge clk); n++; end
        if (!frame_done) chk({tag, "_timeout"}, 64'(frame_done), 64'd1);
        t = cyc;
    endtask

    task automatic check_frame(input string tag, input int s, input logic [31:0] base);
        chk({tag, "_nbits"}, 64'(bits_q.size() - s), 64'(FRAME_BITS));
        if (bits_q.size() - s >= FRAME_BITS) begin
            chk({tag, "_start_zeros"}, 64'(get_word(s)), 64'd0);
            for (int k = 0; k < NUM_LEDS; k++) begin
                chk($sformatf("%s_word%0d", tag, k), 64'(get_word(s + 32 + 32 * k)),
                    64'(model_word(base + 32'(k))));
            end
            chk({tag, "_end_zeros"},
                {get_word(s + 32 + 32 * NUM_LEDS), get_word(s + 64 + 32 * NUM_LEDS)}, 64'd0);
        end
    endtask

    initial begin
        int t0, t1, td, s, n, done_before;
        bit frozen, ready_held;
        logic [1:0] exp_g;

        reset_n = 1'b0; req0 = 1'b0; req1 = 1'b0; pix_valid0 = 1'b0; pix_valid1 = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outs", 64'({grant, busy, pix_ready0, pix_ready1, strip_clk, strip_data,
                               frame_done}), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", 64'(busy), 64'd0);

        // Scenario 1: producer 0 alone, never stalls; req dropped after grant.
        base0 = 32'hE1000001; hs_base0 = hs0; pix_valid0 = 1'b1; req0 = 1'b1;
        wait_start("s1_start", t0);
        s = bits_q.size();
        chk("s1_grant", 64'(grant), 64'd1);
        req0 = 1'b0;
        wait_done("s1_done", t1);
        chk("s1_len", 64'(t1 - t0), 64'(FRAME_CYC));
        check_frame("s1", s, 32'hE1000001);
        @(negedge clk);
        chk("s1_pulse", 64'({frame_done, busy}), 64'b01);
        repeat (FRAME_GAP - 2) @(negedge clk);
        chk("s1_gap_busy", 64'(busy), 64'd1);
        @(negedge clk);
        chk("s1_idle", 64'({busy, grant}), 64'd0);

        // Scenario 2: both requesting, fresh pointer -> 0,1,0,1 with gaps between.
        reset_n = 1'b0; @(negedge clk); reset_n = 1'b1;
        base0 = 32'hE2000001; base1 = 32'hE3000001; pix_valid1 = 1'b1;
        req0 = 1'b1; req1 = 1'b1;
        td = 0;
        for (int f = 0; f < 4; f++) begin
            wait_start($sformatf("s2_start%0d", f), t0);
            s = bits_q.size();
            exp_g = (f % 2 == 1) ? 2'b10 : 2'b01;
            if (exp_g[1]) hs_base1 = hs1; else hs_base0 = hs0;
            chk($sformatf("s2_grant%0d", f), 64'(grant), 64'(exp_g));
            if (f > 0) chk($sformatf("s2_gap%0d", f), 64'(t0 - td), 64'(FRAME_GAP + 1));
            if (f == 3) begin req0 = 1'b0; req1 = 1'b0; end
            wait_done($sformatf("s2_done%0d", f), td);
            check_frame($sformatf("s2_f%0d", f), s, exp_g[1] ? base1 : base0);
        end
        repeat (FRAME_GAP + 1) @(negedge clk);

        // Scenario 3: 10-cycle stall before word 2.
        reset_n = 1'b0; @(negedge clk); reset_n = 1'b1;
        base0 = 32'hA5000001; hs_base0 = hs0; req0 = 1'b1;
        wait_start("s3_start", t0);
        s = bits_q.size();
        req0 = 1'b0;
        n = 0;
        while (!(pix_ready0 && (hs0 - hs_base0 == 2)) && n < 1000) begin
            @(negedge clk); n++;
        end
        chk("s3_reach_word2", 64'(pix_ready0), 64'd1);
        pix_valid0 = 1'b0;
        frozen = 1'b1; ready_held = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (strip_clk !== 1'b0) frozen = 1'b0;
            if (pix_ready0 !== 1'b1) ready_held = 1'b0;
        end
        pix_valid0 = 1'b1;
        chk("s3_clk_frozen", 64'(frozen), 64'd1);
        chk("s3_ready_held", 64'(ready_held), 64'd1);
        wait_done("s3_done", t1);
        chk("s3_len", 64'(t1 - t0), 64'(FRAME_CYC + 10));
        check_frame("s3", s, 32'hA5000001);
        repeat (FRAME_GAP + 1) @(negedge clk);

        // Scenario 4: reset mid-frame (producer 1, word 2); pointer must return to 0.
        base1 = 32'hE4000001; req1 = 1'b1;
        wait_start("s4_start", t0);
        hs_base1 = hs1;
        chk("s4_grant_p1", 64'(grant), 64'd2);
        req1 = 1'b0;
        n = 0;
        while ((hs1 - hs_base1 != 3) && n < 1000) begin @(negedge clk); n++; end
        repeat (5) @(negedge clk);
        done_before = done_cnt;
        reset_n = 1'b0;
        @(negedge clk);
        chk("s4_reset_outs", 64'({grant, busy, pix_ready0, pix_ready1, strip_clk, strip_data,
                                  frame_done}), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("s4_idle", 64'(busy), 64'd0);
        base0 = 32'hE5000001; hs_base0 = hs0; req0 = 1'b1; req1 = 1'b1;
        wait_start("s4_next", t0);
        chk("s4_next_grant", 64'(grant), 64'd1);
        req0 = 1'b0; req1 = 1'b0;
        wait_done("s4_done", t1);
        chk("s4_len", 64'(t1 - t0), 64'(FRAME_CYC));
        repeat (FRAME_GAP + 1) @(negedge clk);
        chk("s4_one_done", 64'(done_cnt - done_before), 64'd1);

        // Scenarios 5/6: producer 1 drops req after grant; brightness field 0x1F.
        base1 = 32'hFF112233; hs_base1 = hs1; req1 = 1'b1;
        wait_start("s6_start", t0);
        s = bits_q.size();
        done_before = done_cnt;
        chk("s6_grant", 64'(grant), 64'd2);
        @(negedge clk);
        req1 = 1'b0;
        wait_done("s6_done", t1);
        chk("s6_grant_held", 64'(grant), 64'd2);
        check_frame("s6", s, 32'hFF112233);
`ifdef STRIP_BRIGHT_CAP_EN
        chk("s5_first_word", 64'(get_word(s + 32)), 64'h0000_0000_E811_2233);
`else
        chk("s5_first_word", 64'(get_word(s + 32)), 64'h0000_0000_FF11_2233);
`endif
        repeat (FRAME_GAP + 3) @(negedge clk);
        chk("s6_one_done", 64'(done_cnt - done_before), 64'd1);
        chk("s6_idle", 64'(busy), 64'd0);
        chk("ungranted_ready", 64'(bad_ready), 64'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
